// File: rtl/des_pkg.sv
// Shared definitions for the DES round controller: FSM states, key codes and the
// per-round key-schedule rotation table.
package des_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } des_state_t;

    localparam logic [1:0] KEY_K1 = 2'd0;
    localparam logic [1:0] KEY_K2 = 2'd1;
    localparam logic [1:0] KEY_K3 = 2'd2;

    localparam int NUM_ROUNDS = 16;

    // Rounds 0, 1, 8 and 15 rotate by one position, all others by two.
    localparam logic [NUM_ROUNDS-1:0] SINGLE_SHIFT_MASK = 16'b1000_0001_0000_0011;

    // Decryption walks the schedule backwards, so its round 0 uses the unrotated key.
    function automatic logic [1:0] shift_for(input logic [3:0] rnd, input logic dec);
        logic [1:0] amt;
        amt = SINGLE_SHIFT_MASK[rnd] ? 2'd1 : 2'd2;
        if (dec && rnd == 4'd0)
            amt = 2'd0;
        return amt;
    endfunction

endpackage

// File: rtl/des_rnd_cnt.sv
// Round counter for the DES controller: counts 0..NUM_ROUNDS-1 while enabled and
// flags the final round.
module des_rnd_cnt
    import des_pkg::*;
(
    input  logic       hclk,
    input  logic       hresetn,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] cnt,
    output logic       last
);

    logic [3:0] cnt_reg;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)
            cnt_reg <= '0;
        else if (clr)
            cnt_reg <= '0;
        else if (en)
            cnt_reg <= cnt_reg + 4'd1;
    end

    assign cnt  = cnt_reg;
    assign last = (cnt_reg == 4'(NUM_ROUNDS - 1));

endmodule

// File: rtl/des_ctrl.sv
// DES / 3DES-EDE round sequencer: drives key loading, block loading and 16 Feistel rounds
// per stage. Triple-DES is only available when DES_CTRL_TDES_EN is defined.
module des_ctrl
    import des_pkg::*;
(
    input  logic       hclk,
    input  logic       hresetn,
    input  logic       start,
    input  logic       tdes,
    input  logic       decrypt,
    input  logic       abort,
    output logic [1:0] key_sel,
    output logic       ld_key,
    output logic       ld_data,
    output logic       round_en,
    output logic [3:0] round,
    output logic       stage_dec,
    output logic [1:0] shift_amt,
    output logic       busy,
    output logic       done
);

    des_state_t state_reg, state_next;
    logic [1:0] stage_reg;
    logic       tdes_reg;
    logic       dec_reg;
    logic       tdes_eff;
    logic       accept;
    logic       last_stage;
    logic [3:0] rnd_cnt;
    logic       rnd_last;
    logic [1:0] stage_key;
    logic       stage_dir;

`ifdef DES_CTRL_TDES_EN
    assign tdes_eff = tdes;
`else
    logic unused_tdes;
    assign unused_tdes = tdes;
    assign tdes_eff    = 1'b0;
`endif

    // Abort has priority over a start arriving in the same cycle.
    assign accept     = (state_reg == ST_IDLE) && start && !abort;
    assign last_stage = !tdes_reg || (stage_reg == 2'd2);

    des_rnd_cnt u_rnd_cnt (
        .hclk    (hclk),
        .hresetn (hresetn),
        .clr     (abort || (state_reg != ST_ROUND)),
        .en      (state_reg == ST_ROUND),
        .cnt     (rnd_cnt),
        .last    (rnd_last)
    );

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            stage_reg <= 2'd0;
            tdes_reg  <= 1'b0;
            dec_reg   <= 1'b0;
        end else if (abort) begin
            stage_reg <= 2'd0;
        end else if (accept) begin
            stage_reg <= 2'd0;
            tdes_reg  <= tdes_eff;
            dec_reg   <= decrypt;
        end else if (state_reg == ST_ROUND && rnd_last && !last_stage) begin
            stage_reg <= stage_reg + 2'd1;
        end
    end

    // EDE: the middle stage runs opposite to the requested direction; decrypt reverses key order.
    always_comb begin
        stage_key = KEY_K1;
        stage_dir = dec_reg;
        if (tdes_reg) begin
            stage_dir = dec_reg ^ (stage_reg == 2'd1);
            case (stage_reg)
                2'd0:    stage_key = dec_reg ? KEY_K3 : KEY_K1;
                2'd1:    stage_key = KEY_K2;
                default: stage_key = dec_reg ? KEY_K1 : KEY_K3;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        key_sel    = KEY_K1;
        ld_key     = 1'b0;
        ld_data    = 1'b0;
        round_en   = 1'b0;
        round      = 4'd0;
        stage_dec  = 1'b0;
        shift_amt  = 2'd0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                if (accept)
                    state_next = ST_LOAD;
            end
            ST_LOAD: begin
                ld_key     = 1'b1;
                ld_data    = (stage_reg == 2'd0);
                key_sel    = stage_key;
                stage_dec  = stage_dir;
                state_next = ST_ROUND;
            end
            ST_ROUND: begin
                round_en  = 1'b1;
                round     = rnd_cnt;
                key_sel   = stage_key;
                stage_dec = stage_dir;
                shift_amt = shift_for(rnd_cnt, stage_dir);
                if (rnd_last)
                    state_next = last_stage ? ST_DONE : ST_LOAD;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (abort)
            state_next = ST_IDLE;
    end

endmodule

// File: doc/des_ctrl.md
DES_CTRL -- requirements
Module: des_ctrl

Interface
REQ-001 SHALL have port hclk, input, 1, sole clock, all state on rising edge.
REQ-002 SHALL have port hresetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, operation request, accepted only in IDLE.
REQ-004 SHALL have port tdes, input, 1, 1=triple-DES EDE, 0=single DES, sampled when start is accepted.
REQ-005 SHALL have port decrypt, input, 1, 1=decrypt, 0=encrypt, sampled when start is accepted.
REQ-006 SHALL have port abort, input, 1, synchronous cancel of the operation in progress.
REQ-007 SHALL have port key_sel, output, 2, selects key 0=K1/q1_all, 1=K2/q2_all, 2=K3/q3_all; 3 is never driven.
REQ-008 SHALL have port ld_key, output, 1, loads the PC1 key schedule from the selected key.
REQ-009 SHALL have port ld_data, output, 1, loads the input block through IP; first stage only.
REQ-010 SHALL have port round_en, output, 1, executes one Feistel round.
REQ-011 SHALL have port round, output, 4, current round index 0..15.
REQ-012 SHALL have port stage_dec, output, 1, current stage runs in decrypt direction.
REQ-013 SHALL have port shift_amt, output, 2, C/D rotation for this round.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port done, output, 1, single-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, ROUND, DONE.
REQ-017 Transitions SHALL be: IDLE->LOAD on accepted start; LOAD->ROUND; ROUND->ROUND while round<15; ROUND(round=15)->LOAD if stages remain, else DONE; DONE->IDLE.
REQ-018 LOAD SHALL assert ld_key; ld_data SHALL be asserted only in the first-stage LOAD.
REQ-019 ROUND SHALL assert round_en; round SHALL start at 0 and increment by 1 per cycle.
REQ-020 round SHALL be 0 outside ROUND.
REQ-021 Single DES SHALL run one stage: K1, direction=decrypt.
REQ-022 3DES encrypt SHALL run K1 enc, K2 dec, K3 enc.
REQ-023 3DES decrypt SHALL run K3 dec, K2 enc, K1 dec.
REQ-024 Encrypt shift_amt SHALL be 1 for rounds 0,1,8,15 and 2 otherwise.
REQ-025 Decrypt shift_amt SHALL be 0 for round 0, 1 for rounds 1,8,15, and 2 otherwise.
REQ-026 shift_amt SHALL be 0 outside ROUND.
REQ-027 Latency with start sampled at cycle T: done SHALL be high at T+18 for single DES and at T+52 for 3DES.
REQ-028 start SHALL be ignored while busy; there SHALL be no queueing.
REQ-029 abort SHALL return the FSM to IDLE on the next edge from any state, with no done pulse.
REQ-030 When abort and start are both high in IDLE, abort SHALL win and start SHALL be dropped.
REQ-031 tdes and decrypt SHALL be latched at acceptance; later changes SHALL have no effect until the next start.

Reset
REQ-032 On hresetn low, the FSM SHALL go to IDLE and stage and round counters SHALL clear, mid-operation included.
REQ-033 Reset values SHALL be: key_sel=0, ld_key=0, ld_data=0, round_en=0, round=0, stage_dec=0, shift_amt=0, busy=0, done=0.

Configuration
REQ-034 With macro DES_CTRL_TDES_EN defined, 3DES SHALL be supported as specified above.
REQ-035 With DES_CTRL_TDES_EN undefined, tdes SHALL be ignored, key_sel SHALL be constant 0, and only one stage SHALL run.

Structure
REQ-036 Shared package des_pkg SHALL hold the FSM state encoding, KEY_K1/K2/K3 codes, NUM_ROUNDS=16, and the shift-amount table.
REQ-037 A sub-module des_rnd_cnt SHALL hold the 4-bit round counter (clear, enable, last flag); the FSM and stage logic SHALL stay in des_ctrl.

Verification
REQ-038 Single-DES encrypt test: start=1, tdes=0, decrypt=0 at T -> ld_key=ld_data=1 at T+1; round 0..15 at T+2..T+17; done at T+18; key_sel=0 throughout.
REQ-039 3DES decrypt test: key_sel sequence 2,1,0; stage_dec sequence 1,0,1; ld_data only in the first LOAD; done at T+52.
REQ-040 Shift-table test: decrypt run -> shift_amt 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-041 Abort test: abort at round 7 of stage 2 -> IDLE next cycle, busy=0, done never asserted; a new start then completes normally.
REQ-042 Start/abort test: start pulses during ROUND are ignored; simultaneous start+abort in IDLE stays in IDLE.
REQ-043 Mid-operation reset test: hresetn low at T+30 -> all outputs at reset values immediately; with DES_CTRL_TDES_EN undefined, tdes=1 runs a single stage with done at T+18.
